// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter (word length, parity, stop length, oversampling)
module uart_tx_cfg #(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic [DBIT-1:0] tx_din,
    input  logic            tx_start,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int TMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int TW   = $clog2(TMAX);
    localparam int BW   = $clog2(DBIT);

    localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state_q;
    logic [TW-1:0]   tick_q;
    logic [BW-1:0]   bit_q;
    logic [DBIT-1:0] shift_q;
    logic            par_q;
    logic            tx_q;
    logic            busy_q;
    logic            done_q;
    logic            tick_end;

    // The current bit period finishes on this cycle's s_tick.
    always_comb begin
        tick_end = 1'b0;
        if (s_tick) begin
            case (state_q)
                START, DATA, PARITY: tick_end = (tick_q == OS_LAST);
                STOP:                tick_end = (tick_q == SB_LAST);
                default:             tick_end = 1'b0;
            endcase
        end
    end

    // Outputs are registered from the current state, so they trail the state by one clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            busy_q <= (state_q != IDLE);
            if (state_q != IDLE && s_tick) begin
                tick_q <= tick_end ? '0 : tick_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (tx_start) begin
                        shift_q <= tx_din;
                        par_q   <= PARITY_ODD[0];
                        tick_q  <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (tick_end) begin
                        bit_q   <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    tx_q <= shift_q[0];
                    if (tick_end) begin
                        par_q   <= par_q ^ shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_q <= (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    tx_q <= par_q;
                    if (tick_end) begin
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (tick_end) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - randomized frame-level check of uart_tx_cfg in five configurations
module tb_uart_tx_cfg;

    localparam int NI = 5;
    localparam int C_DB[NI] = '{8, 8, 8, 7, 9};
    localparam int C_OS[NI] = '{16, 16, 16, 16, 8};
    localparam int C_SB[NI] = '{16, 16, 16, 32, 12};
    localparam int C_PE[NI] = '{0, 1, 1, 0, 1};
    localparam int C_PO[NI] = '{0, 0, 1, 0, 1};

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s_tick;
    logic       start [NI];
    logic [8:0] din   [NI];
    logic       tx_w  [NI];
    logic       busy_w[NI];
    logic       done_w[NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u_8n1 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_din(din[0][7:0]), .tx_start(start[0]),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]));
    uart_tx_cfg #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_din(din[1][7:0]), .tx_start(start[1]),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]));
    uart_tx_cfg #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_din(din[2][7:0]), .tx_start(start[2]),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]));
    uart_tx_cfg #(.DBIT(7), .OVERSAMPLE(16), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u_7n2 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_din(din[3][6:0]), .tx_start(start[3]),
        .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done_tick(done_w[3]));
    uart_tx_cfg #(.DBIT(9), .OVERSAMPLE(8), .SB_TICK(12), .PARITY_EN(1), .PARITY_ODD(1)) u_9o15 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_din(din[4]), .tx_start(start[4]),
        .tx(tx_w[4]), .tx_busy(busy_w[4]), .tx_done_tick(done_w[4]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int frame_ticks(input int inst);
        return C_OS[inst] * (1 + C_DB[inst] + C_PE[inst]) + C_SB[inst];
    endfunction

    // Line level expected while the n-th s_tick of the frame is being consumed.
    function automatic logic exp_level(input int inst, input logic [8:0] data, input int n);
        int   seg;
        logic p;
        seg = n / C_OS[inst];
        if (seg == 0) return 1'b0;
        if (seg <= C_DB[inst]) return data[seg-1];
        if (seg == C_DB[inst] + 1 && C_PE[inst] != 0) begin
            p = C_PO[inst][0];
            for (int i = 0; i < C_DB[inst]; i++) p = p ^ data[i];
            return p;
        end
        return 1'b1;
    endfunction

    task automatic send(input int inst, input logic [8:0] data, input int gap,
                        input int intrude_n, input int abort_n);
        int L;
        int dcount;
        bit aborted;
        L       = frame_ticks(inst);
        dcount  = 0;
        aborted = 1'b0;
        @(negedge clk);
        din[inst]   = data;
        start[inst] = 1'b1;
        @(negedge clk);
        start[inst] = 1'b0;
        chk("accept_tx", tx_w[inst], 1);
        chk("accept_busy", busy_w[inst], 0);
        @(negedge clk);
        chk("start_tx", tx_w[inst], 0);
        chk("start_busy", busy_w[inst], 1);
        for (int n = 0; n < L; n++) begin
            repeat (gap - 1) begin
                @(negedge clk);
                s_tick      = 1'b0;
                start[inst] = 1'b0;
                if (done_w[inst]) dcount++;
            end
            @(negedge clk);
            if (done_w[inst]) dcount++;
            if (n == abort_n) begin
                reset_n = 1'b0;
                #1;
                chk("abort_tx", tx_w[inst], 1);
                chk("abort_busy", busy_w[inst], 0);
                chk("abort_done", done_w[inst], 0);
                repeat (3) @(negedge clk);
                reset_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            s_tick = 1'b1;
            chk("tx_bit", tx_w[inst], exp_level(inst, data, n));
            chk("busy_mid", busy_w[inst], 1);
            if (n == intrude_n) begin
                din[inst]   = 9'h03C;
                start[inst] = 1'b1;
            end
        end
        if (!aborted) begin
            @(negedge clk);
            s_tick      = 1'b0;
            start[inst] = 1'b0;
            chk("done_pulse", done_w[inst], 1);
            chk("busy_fall", busy_w[inst], 0);
            chk("stop_tx", tx_w[inst], 1);
            @(negedge clk);
            chk("done_width", done_w[inst], 0);
        end
        repeat (4) begin
            @(negedge clk);
            if (done_w[inst]) dcount++;
        end
        chk("no_queue_busy", busy_w[inst], 0);
        chk("idle_tx", tx_w[inst], 1);
        chk("extra_done", dcount, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int inst;
        int gap;
        int intr;
        reset_n = 1'b0;
        s_tick  = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0;
            din[i]   = '0;
        end
        #50;
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("reset_tx", tx_w[i], 1);
            chk("reset_busy", busy_w[i], 0);
            chk("reset_done", done_w[i], 0);
        end
        repeat (20) begin
            @(negedge clk);
            s_tick = ~s_tick;
        end
        s_tick = 1'b0;
        chk("idle_ticks_tx", tx_w[0], 1);
        chk("idle_ticks_busy", busy_w[0], 0);

        send(0, 9'h0A5, 10, -1, -1);
        send(1, 9'h0A5, 10, -1, -1);
        send(2, 9'h0A5, 10, -1, -1);
        send(3, 9'h041, 10, -1, -1);
        send(0, 9'h0A5, 3, 40, -1);
        send(0, 9'h0A5, 3, frame_ticks(0) - 1, -1);
        send(0, 9'h0A5, 3, -1, 70);
        send(0, 9'h00F, 3, -1, -1);
        send(4, 9'h1FF, 2, -1, -1);

        for (int k = 0; k < 12; k++) begin
            inst = $urandom_range(0, NI - 1);
            gap  = $urandom_range(2, 4);
            intr = ($urandom_range(0, 1) != 0) ? $urandom_range(0, frame_ticks(inst) - 1) : -1;
            send(inst, 9'($urandom), gap, intr, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
